// File: rtl/tc_ticket_pkg.sv
// Shared helpers for the ticket arbiter: pointer width and modulo-N pointer increment.
package tc_ticket_pkg;

    localparam int MAX_REQ      = 16;
    localparam int RR_PTR_W_MAX = $clog2(MAX_REQ);

    typedef logic [RR_PTR_W_MAX-1:0] rr_ptr_t;

    function automatic int rr_ptr_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic rr_ptr_t next_rr(input rr_ptr_t ptr, input int num_req);
        return (int'(ptr) == num_req - 1) ? '0 : ptr + rr_ptr_t'(1);
    endfunction

endpackage

// File: rtl/tc_rr_picker.sv
// Combinational round-robin picker: first set bit of pending_i scanning upward from rr_ptr_i.
module tc_rr_picker
    import tc_ticket_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PW     = rr_ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [PW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [PW-1:0]      idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [PW:0]          off;
    logic [PW:0]          sum;

    // Rotate so bit 0 is the pointer position; the lowest set bit is then the winner's offset.
    always_comb begin
        dbl = {pending_i, pending_i} >> rr_ptr_i;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = (PW+1)'(k);
        end
        sum = {1'b0, rr_ptr_i} + off;
        if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
        idx_o    = sum[PW-1:0];
        any_o    = |pending_i;
        onehot_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/tc_ticket_arbiter.sv
// Buffers single-cycle requests and grants them round-robin, one per cycle, each with a
// unique ticket drawn from a shared wrapping counter that advances by STRIDE.
module tc_ticket_arbiter
    import tc_ticket_pkg::*;
#(
    parameter int          NUM_REQ   = 4,
    parameter int          BIT_WIDTH = 8,
    parameter int unsigned STRIDE    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cfg_load_i,
    input  logic [BIT_WIDTH-1:0] cfg_value_i,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   pending_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 grant_valid_o,
    output logic [BIT_WIDTH-1:0] ticket_o,
    output logic                 wrap_o
);

    localparam int PW = rr_ptr_w(NUM_REQ);

    logic [BIT_WIDTH-1:0] counter_q, counter_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [PW-1:0]        rr_ptr_q,  rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q,   grant_d;
    logic                 gvld_q,    gvld_d;
    logic [BIT_WIDTH-1:0] ticket_q,  ticket_d;
    logic                 wrap_q,    wrap_d;

    logic [NUM_REQ-1:0]   win_onehot;
    logic [PW-1:0]        win_idx;
    logic                 win_any;
    logic                 issue;
    logic [BIT_WIDTH:0]   incr;

    tc_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .onehot_o  (win_onehot),
        .idx_o     (win_idx),
        .any_o     (win_any)
    );

    assign issue = win_any && !cfg_load_i;
    assign incr  = {1'b0, counter_q} + (BIT_WIDTH+1)'(STRIDE);

    always_comb begin
        counter_d = counter_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = '0;
        gvld_d    = 1'b0;
        ticket_d  = ticket_q;
        wrap_d    = 1'b0;
        // A same-cycle req on the winner re-arms it as a fresh request.
        pending_d = (pending_q & ~(issue ? win_onehot : '0)) | req_i;
        if (cfg_load_i) begin
            counter_d = cfg_value_i;
        end else if (issue) begin
            counter_d = incr[BIT_WIDTH-1:0];
            rr_ptr_d  = PW'(next_rr(rr_ptr_t'(win_idx), NUM_REQ));
            grant_d   = win_onehot;
            gvld_d    = 1'b1;
            ticket_d  = counter_q;
            wrap_d    = incr[BIT_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            counter_q <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            gvld_q    <= 1'b0;
            ticket_q  <= '0;
            wrap_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            gvld_q    <= gvld_d;
            ticket_q  <= ticket_d;
            wrap_q    <= wrap_d;
        end
    end

    assign pending_o     = pending_q;
    assign grant_o       = grant_q;
    assign grant_valid_o = gvld_q;
    assign ticket_o      = ticket_q;
    assign wrap_o        = wrap_q;

endmodule

// File: doc/tc_ticket_arbiter.md
# tc_ticket_arbiter

Shared sequence-number dispenser for the counter datapath. Up to NUM_REQ requesters post single-cycle requests. The block buffers them and grants them in round-robin order, one per cycle. Each grant carries a unique ticket taken from one internal counter that advances by STRIDE. It replaces per-requester counter instances wherever several producers must draw from one monotonic, wrapping sequence.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- BIT_WIDTH, 8, ticket/counter width
- STRIDE, 1, counter increment per issued ticket (1..2^BIT_WIDTH-1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low; clears all state
- cfg_load  in  1  load counter with cfg_value; takes priority over issuing
- cfg_value  in  BIT_WIDTH  new counter value
- req  in  NUM_REQ  per-requester single-cycle request pulse
- pending  out  NUM_REQ  buffered, not-yet-granted requests
- grant  out  NUM_REQ  one-hot, one-cycle grant; all-zero when idle
- grant_valid  out  1  OR of grant
- ticket  out  BIT_WIDTH  ticket for the current grant; holds last value when idle
- wrap  out  1  with grant: this issue overflowed the counter

## Operation
- State:
  - counter (BIT_WIDTH)
  - pending (NUM_REQ)
  - rr_ptr (clog2(NUM_REQ))
  - registered grant/grant_valid/ticket/wrap
- Reset values: every output and state element is 0. Reset mid-operation discards pending requests and any in-flight grant.
- Request capture: req[i]=1 sets pending[i] next edge. A req[i] while pending[i]=1 merges and yields no second ticket.
- Selection (each cycle, cfg_load=0, pending≠0):
  - winner = first set bit of pending, scanning from rr_ptr upward modulo NUM_REQ
  - next edge: pending[winner] cleared, unless req[winner]=1 the same cycle (then it stays set as a new request)
  - grant=onehot(winner), ticket=counter, wrap=carry of counter+STRIDE
  - counter <= (counter+STRIDE) mod 2^BIT_WIDTH
  - rr_ptr <= (winner+1) mod NUM_REQ
- cfg_load=1:
  - counter <= cfg_value
  - no selection that cycle: grant=0 next edge; pending and rr_ptr unchanged
  - new req still captured
- Idle (pending=0, cfg_load=0): grant=0, wrap=0, ticket holds, counter holds.
- Arithmetic: unsigned, modulo 2^BIT_WIDTH. Carry computed on BIT_WIDTH+1 bits.

## Timing
- Uncontested latency: req at edge t, pending visible after t, grant/ticket valid for one cycle after edge t+1 (2 cycles).
- Throughput: one ticket per cycle while pending≠0 and cfg_load=0.
- Worst-case wait with all requesters active: NUM_REQ-1 grants after own request becomes pending.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package tc_ticket_pkg:
  - RR_PTR_W = $clog2(NUM_REQ) helper
  - function next_rr(ptr) for modulo-NUM_REQ increment
- Sub-module tc_rr_picker:
  - combinational round-robin priority picker
  - inputs: pending, rr_ptr
  - outputs: one-hot winner, winner index, any
- Top holds:
  - counter, pending register, pointer
  - output registers and load/issue sequencing

## Test plan
- Reset, then req=0001 for one cycle -> two cycles later grant=0001, ticket=0x00, wrap=0. A second such request -> ticket=0x01.
- After reset, req=1111 in one cycle -> grants 0001,0010,0100,1000 on four consecutive cycles, tickets 0,1,2,3, then pending=0, grant=0.
- Fairness: grant to requester 1, then req=0011 -> requester 0 is not starved; order is 0 then 1 only because rr_ptr=2 wraps. Verify rr_ptr=2 picks 2/3 first when also pending.
- cfg_load with cfg_value=0xFE, STRIDE=1, three requests -> tickets 0xFE (wrap 0), 0xFF (wrap 1), 0x00 (wrap 0).
- cfg_load asserted while pending=0110 -> no grant that cycle, pending stays 0110. The next two grants carry cfg_value and cfg_value+STRIDE.
- rst_n asserted low mid-burst (pending=1011, grant active) -> outputs and pending 0 immediately without clock. After release, the first request yields ticket 0x00 to the lowest-indexed requester.
